audio_mem_responder: RTL and testbench

Memory-side responder for the audio sample read handshake. It accepts single-sample read requests (`read_req` pulse plus a 26-bit word address), fetches the word from the backing memory read port, and holds it on `sample_data` with `data_present` high until the requester pulses `read_ack`. A one-entry sequential prefetch hides memory latency for linear playback. Out-of-range addresses are answered with silence and flagged.

---
 rtl/audio_mem_responder.sv | 141 ++++++++++++++
 tb/tb_audio_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mem_responder.sv
// Memory-side responder for audio sample reads: demand fetch, one-entry
// sequential prefetch, and silence for out-of-range addresses.
module audio_mem_responder #(
  parameter int unsigned       ADDR_W   = 26,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 26'h3FFFFFF,
  parameter bit                PREFETCH = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              read_ack,
  output logic              data_present,
  output logic [DATA_W-1:0] sample_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, PREF} state_e;

  state_e            state_q;
  logic              dp_q, en_q, err_q;
  logic [DATA_W-1:0] sd_q;
  logic [ADDR_W-1:0] ma_q;
  logic              pf_valid_q;
  logic [ADDR_W-1:0] pf_addr_q;
  logic [DATA_W-1:0] pf_data_q;
  logic [ADDR_W-1:0] served_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;

  // Request as seen this edge in PREF: a new pulse supersedes the latched one.
  logic              pend_v;
  logic [ADDR_W-1:0] pend_a;
  // A request to be resolved by the idle rules (range, hit, miss) this edge.
  logic              svc_v, svc_hit;
  logic [ADDR_W-1:0] svc_a;

  always_comb begin
    pend_v  = pend_q | read_req;
    pend_a  = read_req ? req_addr : pend_addr_q;
    svc_v   = 1'b0;
    svc_hit = 1'b0;
    svc_a   = req_addr;
    if (state_q == IDLE && read_req) begin
      svc_v   = 1'b1;
      svc_hit = pf_valid_q && (req_addr == pf_addr_q);
    end else if (state_q == PREF && mem_rd_valid && pend_v && (pend_a != pf_addr_q)) begin
      svc_v = 1'b1;
      svc_a = pend_a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dp_q        <= 1'b0;
      en_q        <= 1'b0;
      err_q       <= 1'b0;
      sd_q        <= '0;
      ma_q        <= '0;
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      served_q    <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      en_q <= 1'b0;
      case (state_q)
        FETCH: if (mem_rd_valid) begin
          sd_q    <= mem_rd_data;
          dp_q    <= 1'b1;
          state_q <= PRESENT;
        end
        PRESENT: if (read_ack) begin
          dp_q <= 1'b0;
          if (PREFETCH && (served_q < MAX_ADDR)) begin
            en_q      <= 1'b1;
            ma_q      <= served_q + 1'b1;
            pf_addr_q <= served_q + 1'b1;
            state_q   <= PREF;
          end else begin
            state_q <= IDLE;
          end
        end
        PREF: begin
          if (read_req) begin
            pend_q      <= 1'b1;
            pend_addr_q <= req_addr;
          end
          if (mem_rd_valid) begin
            pend_q <= 1'b0;
            if (!pend_v) begin
              pf_data_q  <= mem_rd_data;
              pf_valid_q <= 1'b1;
              state_q    <= IDLE;
            end else if (pend_a == pf_addr_q) begin
              sd_q       <= mem_rd_data;
              dp_q       <= 1'b1;
              pf_valid_q <= 1'b0;
              served_q   <= pend_a;
              state_q    <= PRESENT;
            end
          end
        end
        default: ;
      endcase
      if (svc_v) begin
        served_q <= svc_a;
        if (svc_a > MAX_ADDR) begin
          sd_q    <= '0;
          dp_q    <= 1'b1;
          err_q   <= 1'b1;
          state_q <= PRESENT;
        end else if (svc_hit) begin
          sd_q       <= pf_data_q;
          dp_q       <= 1'b1;
          pf_valid_q <= 1'b0;
          state_q    <= PRESENT;
        end else begin
          pf_valid_q <= 1'b0;
          en_q       <= 1'b1;
          ma_q       <= svc_a;
          state_q    <= FETCH;
        end
      end
    end
  end

  assign data_present = dp_q;
  assign sample_data  = sd_q;
  assign mem_rd_en    = en_q;
  assign mem_rd_addr  = ma_q;
  assign addr_err     = err_q;

endmodule

// File: tb/tb_audio_mem_responder.sv
// Bench for audio_mem_responder: three configurations share stimulus, a
// latency-programmable memory model answers the selected instance.
module tb_audio_mem_responder;
  logic        clk = 1'b0, reset_n = 1'b0, read_req = 1'b0, read_ack = 1'b0;
  logic [25:0] req_addr = '0;
  logic        mv_auto = 1'b0, mv_force = 1'b0;
  logic [15:0] mem_data = '0;
  wire         mem_rd_valid = mv_auto | mv_force;

  logic        dp [3];
  logic [15:0] sd [3];
  logic        en [3];
  logic [25:0] ma [3];
  logic        err[3];

  int sel = 0, lat = 3, cnt = 0, overlap = 0, strobes = 0;
  logic [25:0] pend_a = '0, last_strobe = '0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  audio_mem_responder u_a (.clk(clk), .reset_n(reset_n), .read_req(read_req), .req_addr(req_addr),
    .read_ack(read_ack), .data_present(dp[0]), .sample_data(sd[0]), .mem_rd_en(en[0]),
    .mem_rd_addr(ma[0]), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_data), .addr_err(err[0]));
  audio_mem_responder #(.MAX_ADDR(26'h0000FF)) u_b (.clk(clk), .reset_n(reset_n), .read_req(read_req),
    .req_addr(req_addr), .read_ack(read_ack), .data_present(dp[1]), .sample_data(sd[1]),
    .mem_rd_en(en[1]), .mem_rd_addr(ma[1]), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_data),
    .addr_err(err[1]));
  audio_mem_responder #(.PREFETCH(1'b0)) u_c (.clk(clk), .reset_n(reset_n), .read_req(read_req),
    .req_addr(req_addr), .read_ack(read_ack), .data_present(dp[2]), .sample_data(sd[2]),
    .mem_rd_en(en[2]), .mem_rd_addr(ma[2]), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_data),
    .addr_err(err[2]));

  function automatic logic [15:0] memf(input logic [25:0] a);
    if (a == 26'h100) return 16'hBEEF;
    if (a == 26'h101) return 16'h1234;
    return (a[15:0] * 16'h9E37) ^ {6'd0, a[25:16]} ^ 16'h5A5A;
  endfunction

  // Strobe monitor: sees the value held during the cycle that just ended.
  always @(posedge clk) begin
    if (en[sel]) begin
      strobes     <= strobes + 1;
      last_strobe <= ma[sel];
    end
  end

  // Memory model: valid pulse 'lat' cycles after the strobe cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      cnt     <= 0;
      mv_auto <= 1'b0;
    end else begin
      mv_auto <= (cnt == 1);
      if (cnt == 1) mem_data <= memf(pend_a);
      if (en[sel]) begin
        cnt     <= lat;
        pend_a  <= ma[sel];
        overlap <= overlap + ((cnt != 0) ? 1 : 0);
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0; read_req = 1'b0; read_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_req(input logic [25:0] a);
    read_req = 1'b1; req_addr = a;
    @(negedge clk);
    read_req = 1'b0;
  endtask

  task automatic send_ack();
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
  endtask

  task automatic wait_dp(output int cyc);
    cyc = 0;
    while (!dp[sel] && cyc < 40) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({dp[i], sd[i], en[i], ma[i], err[i]} !== 45'd0) begin
        bad++; $display("FAIL reset_vals[%0d]: got %h want 0", i, {dp[i], sd[i], en[i], ma[i], err[i]});
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_hit();
    int cyc, s1;
    sel = 0; lat = 3; do_reset();
    send_req(26'h100);
    total++; if ({en[0], ma[0], dp[0]} !== {1'b1, 26'h100, 1'b0}) begin
      bad++; $display("FAIL miss_strobe: got en=%b addr=%h dp=%b want en=1 addr=100 dp=0", en[0], ma[0], dp[0]); end
    wait_dp(cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL miss_latency: got %0d want 4", cyc); end
    total++; if (sd[0] !== 16'hBEEF) begin bad++; $display("FAIL miss_data: got %h want beef", sd[0]); end
    repeat (2) @(negedge clk);
    total++; if (dp[0] !== 1'b1) begin bad++; $display("FAIL hold_dp: got %b want 1", dp[0]); end
    send_ack();
    total++; if ({dp[0], en[0], ma[0]} !== {1'b0, 1'b1, 26'h101}) begin
      bad++; $display("FAIL pref_strobe: got dp=%b en=%b addr=%h want 0 1 101", dp[0], en[0], ma[0]); end
    repeat (5) @(negedge clk);
    send_req(26'h101);
    s1 = strobes;
    total++; if ({dp[0], sd[0], en[0]} !== {1'b1, 16'h1234, 1'b0}) begin
      bad++; $display("FAIL hit: got dp=%b data=%h en=%b want 1 1234 0", dp[0], sd[0], en[0]); end
    @(negedge clk);
    total++; if (strobes !== s1) begin bad++; $display("FAIL hit_no_read: got %0d want %0d", strobes, s1); end
    send_ack();
  endtask

  task automatic test_pref_mismatch();
    int cyc, s0;
    sel = 0; lat = 3; do_reset();
    send_req(26'h100); wait_dp(cyc);
    send_ack();
    total++; if ({en[0], ma[0]} !== {1'b1, 26'h101}) begin
      bad++; $display("FAIL jump_pref: got en=%b addr=%h want 1 101", en[0], ma[0]); end
    send_req(26'h200000);
    s0 = strobes;
    wait_dp(cyc);
    total++; if (cyc >= 40) begin bad++; $display("FAIL jump_timeout: got %0d cycles want <40", cyc); end
    total++; if (sd[0] !== memf(26'h200000)) begin
      bad++; $display("FAIL jump_data: got %h want %h", sd[0], memf(26'h200000)); end
    total++; if (strobes - s0 !== 1 || last_strobe !== 26'h200000) begin
      bad++; $display("FAIL jump_read: got n=%0d addr=%h want 1 200000", strobes - s0, last_strobe); end
    send_ack();
  endtask

  task automatic test_out_of_range();
    int cyc, s0;
    sel = 1; lat = 2; do_reset();
    send_req(26'h100);
    s0 = strobes;
    total++; if ({dp[1], sd[1], err[1], en[1]} !== {1'b1, 16'h0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL oob: got dp=%b data=%h err=%b en=%b want 1 0 1 0", dp[1], sd[1], err[1], en[1]); end
    send_ack();
    total++; if ({dp[1], en[1]} !== 2'b00) begin bad++; $display("FAIL oob_ack: got %b want 00", {dp[1], en[1]}); end
    repeat (3) @(negedge clk);
    total++; if (err[1] !== 1'b1 || strobes !== s0) begin
      bad++; $display("FAIL oob_sticky: got err=%b reads=%0d want 1 %0d", err[1], strobes, s0); end
    send_req(26'h20); wait_dp(cyc);
    total++; if (sd[1] !== memf(26'h20) || err[1] !== 1'b1) begin
      bad++; $display("FAIL oob_after: got %h err=%b want %h 1", sd[1], err[1], memf(26'h20)); end
    send_ack();
  endtask

  task automatic test_top_boundary();
    int cyc, s0;
    sel = 1; lat = 2; do_reset();
    send_req(26'hFF); wait_dp(cyc);
    total++; if (sd[1] !== memf(26'hFF)) begin bad++; $display("FAIL top_data: got %h want %h", sd[1], memf(26'hFF)); end
    send_ack();
    s0 = strobes;
    total++; if ({dp[1], en[1]} !== 2'b00) begin bad++; $display("FAIL top_no_pref: got %b want 00", {dp[1], en[1]}); end
    repeat (4) @(negedge clk);
    total++; if (strobes !== s0) begin bad++; $display("FAIL top_quiet: got %0d want %0d", strobes, s0); end
    send_req(26'h0);
    total++; if ({en[1], ma[1]} !== {1'b1, 26'h0}) begin
      bad++; $display("FAIL top_idle: got en=%b addr=%h want 1 0", en[1], ma[1]); end
    wait_dp(cyc); send_ack();
  endtask

  task automatic test_back_to_back();
    int cyc, s0;
    sel = 2; do_reset();
    for (int i = 0; i < 3; i++) begin
      lat = $urandom_range(1, 4);
      send_req(26'(i));
      s0 = strobes;
      wait_dp(cyc);
      total++; if (strobes - s0 !== 1 || last_strobe !== 26'(i) || sd[2] !== memf(26'(i))) begin
        bad++; $display("FAIL nopf_req%0d: got n=%0d addr=%h data=%h want 1 %h %h", i, strobes - s0,
                        last_strobe, sd[2], 26'(i), memf(26'(i))); end
      send_ack();
      total++; if ({dp[2], en[2]} !== 2'b00) begin bad++; $display("FAIL nopf_ack%0d: got %b want 00", i, {dp[2], en[2]}); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    sel = 0; lat = 10; do_reset();
    send_req(26'h300);
    total++; if (en[0] !== 1'b1) begin bad++; $display("FAIL rst_pre: got en=%b want 1", en[0]); end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mv_force = 1'b1;
    @(negedge clk);
    mv_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({dp[0], sd[0], en[0], ma[0], err[0]} !== 45'd0) begin
        bad++; $display("FAIL rst_mid%0d: got %h want 0", i, {dp[0], sd[0], en[0], ma[0], err[0]}); end
      @(negedge clk);
    end
  endtask

  // Reference: prefetched word = last in-range served address + 1 (when below MAX),
  // hits are only predictable once the prefetch has landed.
  task automatic test_random();
    logic [25:0] a, prev = '0, pf_exp = '0;
    bit pfv = 0, launched = 0, err_m = 0, settled, oob, hit;
    int gap, cyc, s0;
    sel = 1; lat = 2; do_reset();
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = prev + 1'b1;
        5, 6:          a = 26'($urandom_range(16'hF0, 16'h108));
        default:       a = 26'($urandom_range(0, 16'h1FF));
      endcase
      gap = $urandom_range(0, 7);
      repeat (gap) @(negedge clk);
      settled = !launched || (gap >= lat + 1);
      oob = a > 26'hFF;
      hit = settled && pfv && (a == pf_exp) && !oob;
      err_m |= oob;
      send_req(a);
      s0 = strobes;
      wait_dp(cyc);
      total++; if (cyc >= 40) begin bad++; $display("FAIL rnd_timeout it=%0d addr=%h", it, a); end
      total++; if (sd[1] !== (oob ? 16'h0 : memf(a)) || err[1] !== err_m) begin
        bad++; $display("FAIL rnd_data it=%0d addr=%h: got %h err=%b want %h %b", it, a, sd[1], err[1],
                        oob ? 16'h0 : memf(a), err_m); end
      if (settled) begin
        total++;
        if ((strobes - s0) !== ((hit || oob) ? 0 : 1) || cyc !== ((hit || oob) ? 0 : lat + 1)) begin
          bad++; $display("FAIL rnd_timing it=%0d addr=%h: got reads=%0d cyc=%0d want hit=%b oob=%b lat=%0d",
                          it, a, strobes - s0, cyc, hit, oob, lat); end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      lat = $urandom_range(1, 4);
      send_ack();
      total++;
      if (!oob && a < 26'hFF) begin
        if ({dp[1], en[1], ma[1]} !== {1'b0, 1'b1, a + 1'b1}) begin
          bad++; $display("FAIL rnd_pref it=%0d: got dp=%b en=%b addr=%h want 0 1 %h", it, dp[1], en[1], ma[1], a + 1'b1); end
      end else if ({dp[1], en[1]} !== 2'b00) begin
        bad++; $display("FAIL rnd_nopref it=%0d: got dp=%b en=%b want 0 0", it, dp[1], en[1]);
      end
      if (oob) begin
        if (!settled) pfv = 0;
        launched = 0;
      end else begin
        launched = a < 26'hFF;
        pfv      = a < 26'hFF;
        pf_exp   = a + 1'b1;
      end
      prev = a;
    end
    total++; if (overlap !== 0) begin bad++; $display("FAIL overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_pref_mismatch();
    test_out_of_range();
    test_top_boundary();
    test_back_to_back();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
